// File: rtl/spi_target_pkg.sv
// Shared constants and types for the SPI target memory bridge.
// Holds field widths, the default opcodes and the transaction FSM state encoding.
package spi_target_pkg;

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [CMD_W-1:0] OP_WRITE = 8'h02;
    localparam logic [CMD_W-1:0] OP_READ  = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_DUMMY,
        ST_RDATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises the asynchronous SPI pins into clk_i and detects edges.
// Ports: clk_i/rst_i clock and async active-high reset; sclk/cs/sdi raw pins;
//        sclk_rise/sclk_fall/cs_fall/cs_rise one-cycle edge pulses; sdi_s data
//        aligned with the sclk edge pulses.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk,
    input  logic cs,
    input  logic sdi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic sdi_s
);

    logic [SYNC_STAGES-1:0] sclk_ff;
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] sdi_ff;
    logic                   sclk_prev;
    logic                   cs_prev;

    // cs synchroniser resets to the idle (high) level so reset release creates no edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_ff   <= '0;
            cs_ff     <= '1;
            sdi_ff    <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            sdi_s     <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], sclk};
            cs_ff     <= {cs_ff[SYNC_STAGES-2:0], cs};
            sdi_ff    <= {sdi_ff[SYNC_STAGES-2:0], sdi};
            sclk_prev <= sclk_ff[SYNC_STAGES-1];
            cs_prev   <= cs_ff[SYNC_STAGES-1];
            sclk_rise <= sclk_ff[SYNC_STAGES-1] & ~sclk_prev;
            sclk_fall <= ~sclk_ff[SYNC_STAGES-1] & sclk_prev;
            cs_fall   <= ~cs_ff[SYNC_STAGES-1] & cs_prev;
            cs_rise   <= cs_ff[SYNC_STAGES-1] & ~cs_prev;
            sdi_s     <= sdi_ff[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/spi_target_mem.sv
// SPI target that decodes cmd/addr/data frames into req/gnt/rvalid memory accesses.
// Ports: clk_i/rst_i clock and async active-high reset; spi_* SPI pins (mode 0,
//        cs active low, sdo/sdo_oe driven from sclk falls); mem_* memory request
//        port (req held until gnt, read data on a one-cycle rvalid); busy_o frame
//        or access in flight; err_o sticky error until reset.
module spi_target_mem
    import spi_target_pkg::*;
#(
    parameter int unsigned      DUMMY_CYCLES = 34,
    parameter logic [CMD_W-1:0] CMD_WRITE    = OP_WRITE,
    parameter logic [CMD_W-1:0] CMD_READ     = OP_READ,
    parameter int unsigned      SYNC_STAGES  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_i,
    input  logic              spi_sdi_i,
    output logic              spi_sdo_o,
    output logic              spi_sdo_oe_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned CNT_MAX = (DUMMY_CYCLES > DATA_W) ? DUMMY_CYCLES : DATA_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, sdi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sclk      (spi_sclk_i),
        .cs        (spi_cs_i),
        .sdi       (spi_sdi_i),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .sdi_s     (sdi_s)
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic                is_read_q, is_read_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   rd_sr_q, rd_sr_d;
    logic                sdo_q, sdo_d, oe_q, oe_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_pend_q, rd_pend_d;
    logic                rd_live_q, rd_live_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_ok_q, rdata_ok_d;
    logic                err_q, err_d, busy_q, busy_d;

    logic                issue_wr, issue_rd;
    logic [ADDR_W-1:0]   iss_addr;
    logic [DATA_W-1:0]   iss_wdata;
    logic [DATA_W-1:0]   rx;
    logic [DATA_W-1:0]   load_data;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            rd_sr_q    <= '0;
            sdo_q      <= 1'b0;
            oe_q       <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_live_q  <= 1'b0;
            rdata_q    <= '0;
            rdata_ok_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            is_read_q  <= is_read_d;
            addr_q     <= addr_d;
            rd_sr_q    <= rd_sr_d;
            sdo_q      <= sdo_d;
            oe_q       <= oe_d;
            req_q      <= req_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            rd_pend_q  <= rd_pend_d;
            rd_live_q  <= rd_live_d;
            rdata_q    <= rdata_d;
            rdata_ok_q <= rdata_ok_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state, shift/count and memory-request logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        is_read_d  = is_read_q;
        addr_d     = addr_q;
        rd_sr_d    = rd_sr_q;
        sdo_d      = sdo_q;
        oe_d       = oe_q;
        req_d      = req_q;
        we_d       = we_q;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        rd_pend_d  = rd_pend_q;
        rd_live_d  = rd_live_q;
        rdata_d    = rdata_q;
        rdata_ok_d = rdata_ok_q;
        err_d      = err_q;
        issue_wr   = 1'b0;
        issue_rd   = 1'b0;
        iss_addr   = addr_q;
        iss_wdata  = wdata_q;
        load_data  = '0;
        rx         = {sr_q[DATA_W-2:0], sdi_s};

        // Responses only land while the issuing frame is still live
        if (mem_rvalid_i && rd_pend_q) begin
            rd_pend_d = 1'b0;
            if (rd_live_q) begin
                rdata_d    = mem_rdata_i;
                rdata_ok_d = 1'b1;
            end
        end
        if (req_q && mem_gnt_i) begin
            req_d = 1'b0;
        end

        if (cs_rise) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            oe_d       = 1'b0;
            sdo_d      = 1'b0;
            rd_live_d  = 1'b0;
            rdata_ok_d = 1'b0;
        end else if (cs_fall) begin
            // A coincident sclk edge is deliberately not counted
            state_d = ST_CMD;
            cnt_d   = '0;
            oe_d    = 1'b0;
            sdo_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_CMD: begin
                    if (sclk_rise) begin
                        sr_d = rx;
                        if (cnt_q == CNT_W'(CMD_W - 1)) begin
                            cnt_d = '0;
                            if (rx[CMD_W-1:0] == CMD_WRITE) begin
                                state_d   = ST_ADDR;
                                is_read_d = 1'b0;
                            end else if (rx[CMD_W-1:0] == CMD_READ) begin
                                state_d   = ST_ADDR;
                                is_read_d = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        sr_d = rx;
                        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                            cnt_d  = '0;
                            addr_d = rx;
                            if (is_read_q) begin
                                state_d  = ST_DUMMY;
                                issue_rd = 1'b1;
                                iss_addr = rx;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        sr_d = rx;
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            cnt_d     = '0;
                            state_d   = ST_CMD;
                            issue_wr  = 1'b1;
                            iss_wdata = rx;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sclk_rise && cnt_q != CNT_W'(DUMMY_CYCLES)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (sclk_fall && cnt_q == CNT_W'(DUMMY_CYCLES)) begin
                        // Late data cannot be recovered: shift zeros and flag it
                        if (rdata_ok_q) begin
                            load_data = rdata_q;
                        end else begin
                            err_d = 1'b1;
                        end
                        sdo_d      = load_data[DATA_W-1];
                        rd_sr_d    = {load_data[DATA_W-2:0], 1'b0};
                        oe_d       = 1'b1;
                        cnt_d      = '0;
                        rdata_ok_d = 1'b0;
                        rd_live_d  = 1'b0;
                        state_d    = ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (sclk_rise && cnt_q != CNT_W'(DATA_W)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (sclk_fall) begin
                        if (cnt_q == CNT_W'(DATA_W)) begin
                            oe_d    = 1'b0;
                            sdo_d   = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_CMD;
                        end else begin
                            sdo_d   = rd_sr_q[DATA_W-1];
                            rd_sr_d = {rd_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end

        // One request slot: an issue while it is still ungranted is dropped
        if (issue_wr || issue_rd) begin
            if (req_q && !mem_gnt_i) begin
                err_d = 1'b1;
            end else begin
                req_d   = 1'b1;
                we_d    = issue_wr;
                maddr_d = iss_addr;
                wdata_d = iss_wdata;
                if (issue_rd) begin
                    rd_pend_d  = 1'b1;
                    rd_live_d  = 1'b1;
                    rdata_ok_d = 1'b0;
                end
            end
        end

        busy_d = (state_d != ST_IDLE) | req_d | rd_pend_d;
    end

    assign spi_sdo_o    = sdo_q;
    assign spi_sdo_oe_o = oe_q;
    assign mem_req_o    = req_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = maddr_q;
    assign mem_wdata_o  = wdata_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;

endmodule
